// File: rtl/ofdm_remove_cp_cfg.sv
// Runtime-configurable cyclic-prefix remover between frame sync and FFT.
// Ports: i_clk/i_reset, sample in (i_valid, in_data_i/q, i_frame_sync),
//   config (i_fft_log2, i_cp_len_first, i_cp_len_norm, i_cp_offset),
//   registered sample out (out_valid, out_data_i/q, o_sop, o_eop, o_sym_idx),
//   status (o_cp_removed comb, o_abort pulse, o_cfg_err sticky).
module ofdm_remove_cp_cfg #(
  parameter int DATA_SIZE     = 16,
  parameter int MAX_FFT_LOG2  = 12,
  parameter int CP_WIDTH      = 10,
  parameter int SYMS_PER_SLOT = 7
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [DATA_SIZE-1:0] in_data_i,
  input  logic [DATA_SIZE-1:0] in_data_q,
  input  logic                 i_frame_sync,
  input  logic [3:0]           i_fft_log2,
  input  logic [CP_WIDTH-1:0]  i_cp_len_first,
  input  logic [CP_WIDTH-1:0]  i_cp_len_norm,
  input  logic [CP_WIDTH-1:0]  i_cp_offset,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data_i,
  output logic [DATA_SIZE-1:0] out_data_q,
  output logic                 o_sop,
  output logic                 o_eop,
  output logic [7:0]           o_sym_idx,
  output logic                 o_cp_removed,
  output logic                 o_abort,
  output logic                 o_cfg_err
);

  localparam int SW = MAX_FFT_LOG2 + 1;
  localparam logic [3:0] LOG2_MIN = 4'd3;
  localparam logic [3:0] LOG2_MAX = 4'(MAX_FFT_LOG2);
  localparam logic [7:0] SYM_LAST = 8'(SYMS_PER_SLOT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CP,
    DATA,
    ERR
  } state_t;

  function automatic logic [SW-1:0] fft_len(
    input logic [3:0] lg
  );
    return SW'(1) << lg;
  endfunction

  function automatic logic [SW-1:0] win_start(
    input logic [CP_WIDTH-1:0] cp,
    input logic [CP_WIDTH-1:0] off
  );
    return SW'(cp) - SW'(off);
  endfunction

  function automatic logic in_win(
    input logic [SW-1:0] pos,
    input logic [SW-1:0] st,
    input logic [SW-1:0] n
  );
    return (pos >= st) && (pos < st + n);
  endfunction

  state_t state, state_nxt;

  logic [SW-1:0]       s, s_nxt;
  logic [7:0]          sym, sym_nxt;
  logic [3:0]          log2_q;
  logic [CP_WIDTH-1:0] cpf_q;
  logic [CP_WIDTH-1:0] cpn_q;
  logic [CP_WIDTH-1:0] off_q;

  logic                sync;
  logic                legal;
  logic                run;
  logic [SW-1:0]       n_q;
  logic [SW-1:0]       n_in;
  logic [CP_WIDTH-1:0] cp_q;
  logic [SW-1:0]       st_q;
  logic [SW-1:0]       last_q;
  logic                wrap;
  logic [7:0]          sym_inc;
  logic [SW-1:0]       s_adv;
  logic [7:0]          sym_adv;
  logic [CP_WIDTH-1:0] cp_adv;
  logic [SW-1:0]       st_adv;
  logic [SW-1:0]       st_in;

  logic                fwd;
  logic                sop_c;
  logic                eop_c;
  logic [7:0]          sym_c;

  assign sync = i_valid & i_frame_sync;

  assign legal = (i_fft_log2 >= LOG2_MIN)
              && (i_fft_log2 <= LOG2_MAX)
              && (i_cp_offset <= i_cp_len_first)
              && (i_cp_offset <= i_cp_len_norm);

  assign run = (state == CP) || (state == DATA);

  assign n_q    = fft_len(log2_q);
  assign n_in   = fft_len(i_fft_log2);
  assign cp_q   = (sym == 8'd0) ? cpf_q : cpn_q;
  assign st_q   = win_start(cp_q, off_q);
  assign last_q = SW'(cp_q) + n_q - SW'(1);

  // Position of the sample after the current one, with symbol/slot wrap.
  assign wrap    = (s == last_q);
  assign sym_inc = (sym == SYM_LAST) ? 8'd0 : sym + 8'd1;
  assign s_adv   = wrap ? '0 : s + SW'(1);
  assign sym_adv = wrap ? sym_inc : sym;
  assign cp_adv  = (sym_adv == 8'd0) ? cpf_q : cpn_q;
  assign st_adv  = win_start(cp_adv, off_q);
  assign st_in   = win_start(i_cp_len_first, i_cp_offset);

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    sym_nxt   = sym;
    if (sync) begin
      // The sync sample is s=0 of symbol 0; N >= 8 so no wrap here.
      sym_nxt = 8'd0;
      if (legal) begin
        s_nxt     = SW'(1);
        state_nxt = in_win(SW'(1), st_in, n_in) ? DATA : CP;
      end else begin
        s_nxt     = '0;
        state_nxt = ERR;
      end
    end else if (i_valid && run) begin
      s_nxt     = s_adv;
      sym_nxt   = sym_adv;
      state_nxt = in_win(s_adv, st_adv, n_q) ? DATA : CP;
    end
  end

  // A sync sample is forwarded only when its symbol has no prefix left.
  assign fwd   = sync ? (legal && (i_cp_len_first == i_cp_offset))
                      : (i_valid && (state == DATA));
  assign sop_c = sync | (s == st_q);
  assign eop_c = !sync && (s == st_q + n_q - SW'(1));
  assign sym_c = sync ? 8'd0 : sym;

  assign o_cp_removed = fwd;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      s          <= '0;
      sym        <= '0;
      log2_q     <= '0;
      cpf_q      <= '0;
      cpn_q      <= '0;
      off_q      <= '0;
      o_cfg_err  <= 1'b0;
      out_valid  <= 1'b0;
      out_data_i <= '0;
      out_data_q <= '0;
      o_sop      <= 1'b0;
      o_eop      <= 1'b0;
      o_sym_idx  <= '0;
      o_abort    <= 1'b0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      sym   <= sym_nxt;
      if (sync) begin
        log2_q    <= i_fft_log2;
        cpf_q     <= i_cp_len_first;
        cpn_q     <= i_cp_len_norm;
        off_q     <= i_cp_offset;
        o_cfg_err <= !legal;
      end
      out_valid  <= fwd;
      out_data_i <= fwd ? in_data_i : '0;
      out_data_q <= fwd ? in_data_q : '0;
      o_sop      <= fwd & sop_c;
      o_eop      <= fwd & eop_c;
      o_sym_idx  <= fwd ? sym_c : 8'd0;
      // In DATA the pending position is inside the window: EOP not yet sent.
      o_abort    <= sync && (state == DATA);
    end
  end

endmodule

// File: tb/tb_ofdm_remove_cp_cfg.sv
// Scoreboard bench for ofdm_remove_cp_cfg: slot-position reference model,
// directed test-plan phases, then randomized configs/gaps/resyncs.
module tb_ofdm_remove_cp_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        fsync = 1'b0;
  logic [15:0] di = '0;
  logic [15:0] dq = '0;
  logic [3:0]  lg = '0;
  logic [9:0]  cpf = '0;
  logic [9:0]  cpn = '0;
  logic [9:0]  off = '0;

  logic        out_valid;
  logic [15:0] out_data_i;
  logic [15:0] out_data_q;
  logic        o_sop;
  logic        o_eop;
  logic [7:0]  o_sym_idx;
  logic        o_cp_removed;
  logic        o_abort;
  logic        o_cfg_err;

  ofdm_remove_cp_cfg #(
    .DATA_SIZE(16),
    .MAX_FFT_LOG2(12),
    .CP_WIDTH(10),
    .SYMS_PER_SLOT(7)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_valid(valid),
    .in_data_i(di),
    .in_data_q(dq),
    .i_frame_sync(fsync),
    .i_fft_log2(lg),
    .i_cp_len_first(cpf),
    .i_cp_len_norm(cpn),
    .i_cp_offset(off),
    .out_valid(out_valid),
    .out_data_i(out_data_i),
    .out_data_q(out_data_q),
    .o_sop(o_sop),
    .o_eop(o_eop),
    .o_sym_idx(o_sym_idx),
    .o_cp_removed(o_cp_removed),
    .o_abort(o_abort),
    .o_cfg_err(o_cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] di;
    logic [15:0] dq;
    logic        sop;
    logic        eop;
    logic [7:0]  sym;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   sop_data[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   out_cnt = 0;
  int   eop_cnt = 0;
  int   act_abort = 0;
  int   exp_abort = 0;

  // Reference model state: slot position counted in accepted samples.
  bit m_run = 0;
  bit m_err = 0;
  int m_pos = 0;
  int m_sym = 0;
  int m_lg = 0;
  int m_cpf = 0;
  int m_cpn = 0;
  int m_off = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_inwin();
    int cp, st, n;
    cp = (m_sym == 0) ? m_cpf : m_cpn;
    n  = 1 << m_lg;
    st = cp - m_off;
    return (m_pos >= st) && (m_pos < st + n);
  endfunction

  task automatic model(input logic sy, input logic [15:0] a,
                       input logic [15:0] b, output logic cr);
    int cp, n, st;
    exp_t e;
    cr = 1'b0;
    if (sy) begin
      if (m_run && m_inwin()) exp_abort++;
      m_lg  = int'(lg);
      m_cpf = int'(cpf);
      m_cpn = int'(cpn);
      m_off = int'(off);
      if (m_lg >= 3 && m_lg <= 12 && m_off <= m_cpf && m_off <= m_cpn) begin
        m_run = 1; m_err = 0; m_pos = 0; m_sym = 0;
      end else begin
        m_run = 0; m_err = 1;
      end
    end
    if (m_run) begin
      cp = (m_sym == 0) ? m_cpf : m_cpn;
      n  = 1 << m_lg;
      st = cp - m_off;
      if (m_pos >= st && m_pos < st + n) begin
        e.di  = a;
        e.dq  = b;
        e.sop = (m_pos == st);
        e.eop = (m_pos == st + n - 1);
        e.sym = 8'(m_sym);
        e.cyc = cyc;
        q.push_back(e);
        cr = 1'b1;
      end
      m_pos++;
      if (m_pos == cp + n) begin
        m_pos = 0;
        m_sym = (m_sym + 1) % 7;
      end
    end
  endtask

  task automatic step(input logic v, input logic sy,
                      input logic [15:0] a, input logic [15:0] b);
    logic cr;
    @(posedge clk);
    #1;
    chk("cfg_err", o_cfg_err, m_err);
    valid = v;
    fsync = sy;
    di    = a;
    dq    = b;
    cr    = 1'b0;
    if (v) model(sy, a, b, cr);
    #1;
    chk("cp_removed", o_cp_removed, cr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic set_cfg(input int l, input int f, input int nn, input int o);
    lg  = 4'(l);
    cpf = 10'(f);
    cpn = 10'(nn);
    off = 10'(o);
  endtask

  task automatic ramp(input int base, input int cnt, input bit first_sync);
    for (int k = 0; k < cnt; k++)
      step(1'b1, first_sync && k == 0, 16'(base + k), 16'(base + k) ^ 16'hFFFF);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    chk("cfg_err", o_cfg_err, m_err);
    rst   = 1'b1;
    valid = 1'b1;
    fsync = 1'b0;
    di    = 16'($urandom);
    m_run = 0;
    m_err = 0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    chk("reset_zero", {out_valid, out_data_i, out_data_q, o_sop, o_eop,
                       o_sym_idx, o_abort, o_cfg_err}, 0);
  endtask

  task automatic phase_start();
    sop_data.delete();
    out_cnt = 0;
    eop_cnt = 0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got data %0d expected no output (t=%0t)",
                   out_data_i, $time);
        end else begin
          e = q.pop_front();
          chk("data_i", out_data_i, e.di);
          chk("data_q", out_data_q, e.dq);
          chk("sop", o_sop, e.sop);
          chk("eop", o_eop, e.eop);
          chk("sym_idx", o_sym_idx, e.sym);
          chk("latency", cyc - e.cyc, 1);
        end
        out_cnt++;
        if (o_sop) sop_data.push_back(int'(out_data_i));
        if (o_eop) eop_cnt++;
      end else if (!rst) begin
        chk("idle_zero", {out_data_i, out_data_q, o_sop, o_eop, o_sym_idx}, 0);
      end
      if (o_abort === 1'b1) act_abort++;
    end
  end

  initial begin
    int k;
    int ab0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_state", {out_valid, out_data_i, out_data_q, o_sop, o_eop,
                        o_sym_idx, o_abort, o_cfg_err, o_cp_removed}, 0);
    idle(2);

    // Basic slot, two full slots.
    phase_start();
    set_cfg(4, 6, 4, 0);
    ramp(0, 284, 1);
    idle(3);
    chk("basic_count", out_cnt, 224);
    chk("basic_eops", eop_cnt, 14);
    chk("basic_sop0", sop_data[0], 6);
    chk("basic_sop1", sop_data[1], 26);
    chk("basic_slot2_sop0", sop_data[7], 148);

    // Window offset.
    phase_start();
    set_cfg(4, 6, 4, 2);
    ramp(0, 284, 1);
    idle(3);
    chk("off_count", out_cnt, 224);
    chk("off_sop0", sop_data[0], 4);
    chk("off_sop1", sop_data[1], 24);

    // Random valid gaps, frame_sync noise on idle cycles.
    phase_start();
    set_cfg(4, 6, 4, 0);
    k = 0;
    while (k < 284) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1'b1, k == 0, 16'(k), 16'(k) ^ 16'hFFFF);
        k++;
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      end
    end
    idle(3);
    chk("gap_count", out_cnt, 224);
    chk("gap_sop1", sop_data[1], 26);

    // Resync at sample 12 of symbol 1.
    phase_start();
    ab0 = act_abort;
    ramp(0, 34, 1);
    step(1'b1, 1'b1, 16'd34, 16'd34 ^ 16'hFFFF);
    ramp(35, 66, 0);
    idle(3);
    chk("resync_abort", act_abort - ab0, 1);
    chk("resync_eops", eop_cnt, 4);
    chk("resync_sop2", sop_data[2], 40);

    // Illegal config, then recovery.
    phase_start();
    set_cfg(4, 6, 4, 5);
    ramp(0, 40, 1);
    idle(2);
    chk("illegal_no_out", out_cnt, 0);
    chk("illegal_err", o_cfg_err, 1);
    set_cfg(4, 6, 4, 0);
    ramp(0, 40, 1);
    idle(3);
    chk("recover_err", o_cfg_err, 0);
    chk("recover_sop0", sop_data[0], 6);

    // Reset mid-DATA.
    phase_start();
    ramp(0, 30, 1);
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
    ramp(100, 60, 1);
    idle(3);
    chk("reset_sop2", sop_data[2], 106);

    // Randomized configs, gaps, resyncs and mid-slot config changes.
    set_cfg(3, 2, 1, 0);
    step(1'b1, 1'b1, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 4000; i++) begin
      logic v, sy;
      if ($urandom_range(0, 39) == 0) begin
        set_cfg($urandom_range(2, 6), $urandom_range(0, 12),
                $urandom_range(0, 12), $urandom_range(0, 5));
        if ($urandom_range(0, 9) == 0) lg = 4'd13;
      end
      v  = ($urandom_range(0, 9) < 7);
      sy = v ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 29) == 0);
      step(v, sy, 16'($urandom), 16'($urandom));
    end
    idle(4);
    chk("queue_empty", q.size(), 0);
    chk("abort_count", act_abort, exp_abort);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
